fpu_test_sequencer: RTL and testbench



---
 rtl/fpu_test_pkg.sv | 19 +
 rtl/test_vector_rom.sv | 58 +++++
 rtl/fpu_test_sequencer.sv | 144 ++++++++++++++
 tb/tb_fpu_test_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_test_pkg.sv
// Shared types and constants for the FPU test sequencer.
package fpu_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        SHOW  = 2'd3
    } state_e;

    localparam logic [31:0] ERROR_PATTERN = 32'hDEAD_BEEF;

    // One operand pair as stored in the vector ROM.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } vector_t;

endpackage

// File: rtl/test_vector_rom.sv
// Synchronous-read operand ROM of IEEE-754 pairs, registered output, 1-cycle latency.
module test_vector_rom
    import fpu_test_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(NUM_VECTORS)-1:0] addr,
    output vector_t                        data
);

    localparam int unsigned ADDR_W = $clog2(NUM_VECTORS);

    logic [7:0] addr_ext;
    vector_t    data_d;
    vector_t    data_q;

    // Vector contents; entries past the directed set get a simple index-tagged pattern.
    always_comb begin
        addr_ext = 8'(addr);
        data_d   = '0;
        case (addr_ext)
            8'd0:    data_d = {32'h3FC0_0000, 32'h4000_0000}; // 1.5, 2.0
            8'd1:    data_d = {32'h4049_0FDB, 32'h402D_F854}; // pi, e
            8'd2:    data_d = {32'hBF80_0000, 32'h3F80_0000}; // -1.0, 1.0
            8'd3:    data_d = {32'h7F80_0000, 32'h0000_0000}; // +inf, +0
            8'd4:    data_d = {32'h7FC0_0000, 32'h3F80_0000}; // qNaN, 1.0
            8'd5:    data_d = {32'h0000_0001, 32'h0000_0001}; // min denormals
            8'd6:    data_d = {32'h7F7F_FFFF, 32'h7F7F_FFFF}; // max finite
            8'd7:    data_d = {32'h8000_0000, 32'h0000_0000}; // -0, +0
            8'd8:    data_d = {32'h4120_0000, 32'h40A0_0000}; // 10, 5
            8'd9:    data_d = {32'h3DCC_CCCD, 32'h3E4C_CCCD}; // 0.1, 0.2
            8'd10:   data_d = {32'hC2C8_0000, 32'h42C8_0000}; // -100, 100
            8'd11:   data_d = {32'h0080_0000, 32'h3F00_0000}; // min normal, 0.5
            8'd12:   data_d = {32'h4B80_0000, 32'h3F80_0000}; // 2^24, 1.0
            8'd13:   data_d = {32'h3EAA_AAAB, 32'h4040_0000}; // 1/3, 3
            8'd14:   data_d = {32'hFF80_0000, 32'h7F80_0000}; // -inf, +inf
            8'd15:   data_d = {32'h447A_0000, 32'h3A83_126F}; // 1000, 0.001
            default: data_d = {8'h40, addr_ext, 16'h0000, 32'h3F80_0000};
        endcase
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

    logic unused_addr_w;
    assign unused_addr_w = ^ADDR_W;

endmodule

// File: rtl/fpu_test_sequencer.sv
// Button-driven sequencer: issues ROM operand pairs to an FPU and shows results bytewise on LEDs.
module fpu_test_sequencer
    import fpu_test_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        button_pulse,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    output logic        fpu_start,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [7:0]  leds,
    output logic        busy,
    output logic        error
);

    localparam int unsigned IDX_W = $clog2(NUM_VECTORS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   vec_idx_q,   vec_idx_d;
    logic [1:0]         byte_sel_q,  byte_sel_d;
    logic [CNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic [31:0]        result_q,    result_d;
    logic [31:0]        fpu_a_q,     fpu_a_d;
    logic [31:0]        fpu_b_q,     fpu_b_d;
    logic               fpu_start_q, fpu_start_d;
    logic [7:0]         leds_q,      leds_d;
    logic               error_q,     error_d;
    vector_t            rom_data;

    // ROM is addressed with the next index so the pair is ready during the ISSUE cycle.
    test_vector_rom #(
        .NUM_VECTORS (NUM_VECTORS)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (vec_idx_d),
        .data  (rom_data)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        byte_sel_d  = byte_sel_q;
        wait_cnt_d  = wait_cnt_q;
        result_d    = result_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_start_d = 1'b0;
        leds_d      = leds_q;
        error_d     = error_q;

        case (state_q)
            IDLE: begin
                if (button_pulse) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d     = WAIT;
                fpu_a_d     = rom_data.a;
                fpu_b_d     = rom_data.b;
                fpu_start_d = 1'b1;
                wait_cnt_d  = '0;
                error_d     = 1'b0;
            end
            WAIT: begin
                if (fpu_done) begin
                    result_d   = fpu_result;
                    byte_sel_d = 2'd3;
                    state_d    = SHOW;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    result_d   = ERROR_PATTERN;
                    error_d    = 1'b1;
                    byte_sel_d = 2'd3;
                    state_d    = SHOW;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            SHOW: begin
                if (button_pulse) begin
                    if (byte_sel_q != 2'd0) begin
                        byte_sel_d = byte_sel_q - 2'd1;
                    end else begin
                        vec_idx_d = vec_idx_q + IDX_W'(1);
                        state_d   = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // LEDs track the selected byte while showing; otherwise they hold (IDLE only follows reset).
        if (state_d == SHOW) begin
            leds_d = result_d[{byte_sel_d, 3'b000} +: 8];
        end else if (state_d == IDLE) begin
            leds_d = 8'h00;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            vec_idx_q   <= '0;
            byte_sel_q  <= 2'd3;
            wait_cnt_q  <= '0;
            result_q    <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_start_q <= 1'b0;
            leds_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            byte_sel_q  <= byte_sel_d;
            wait_cnt_q  <= wait_cnt_d;
            result_q    <= result_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_start_q <= fpu_start_d;
            leds_q      <= leds_d;
            error_q     <= error_d;
        end
    end

    assign fpu_start = fpu_start_q;
    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign leds      = leds_q;
    assign error     = error_q;
    assign busy      = (state_q == ISSUE) || (state_q == WAIT);

endmodule

// File: tb/tb_fpu_test_sequencer.sv
// Directed self-checking bench for fpu_test_sequencer with an operand scoreboard.
module tb_fpu_test_sequencer;

    localparam int unsigned NV = 4;
    localparam int unsigned TO = 16;

    logic        clk;
    logic        reset;
    logic        button_pulse;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic        fpu_start;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [7:0]  leds;
    logic        busy;
    logic        error;

    int          n_tests;
    int          n_fail;
    int          n_starts;
    logic [63:0] exp_q[$];
    int          exp_idx;

    fpu_test_sequencer #(
        .NUM_VECTORS (NV),
        .TIMEOUT     (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_pulse (button_pulse),
        .fpu_done     (fpu_done),
        .fpu_result   (fpu_result),
        .fpu_start    (fpu_start),
        .fpu_a        (fpu_a),
        .fpu_b        (fpu_b),
        .leds         (leds),
        .busy         (busy),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rom_model(input int idx);
        case (idx)
            0:       return {32'h3FC0_0000, 32'h4000_0000};
            1:       return {32'h4049_0FDB, 32'h402D_F854};
            2:       return {32'hBF80_0000, 32'h3F80_0000};
            3:       return {32'h7F80_0000, 32'h0000_0000};
            default: return 64'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        button_pulse = 1'b1;
        tick();
        button_pulse = 1'b0;
    endtask

    task automatic expect_issue();
        exp_q.push_back(rom_model(exp_idx));
    endtask

    // Every start pulse must carry the next expected operand pair.
    always @(negedge clk) begin
        if (fpu_start) begin
            n_starts++;
            check("start_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("start_operands", {fpu_a, fpu_b}, e);
            end
        end
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        n_starts     = 0;
        exp_idx      = 0;
        reset        = 1'b0;
        button_pulse = 1'b0;
        fpu_done     = 1'b0;
        fpu_result   = 32'h0;

        // Reset state
        repeat (3) tick();
        check("rst_outputs", {31'h0, fpu_start, leds, busy, error, 22'h0}, 64'h0);
        check("rst_operands", {fpu_a, fpu_b}, 64'h0);
        reset = 1'b1;
        repeat (6) tick();
        check("idle_outputs", {48'h0, leds, 5'h0, fpu_start, busy, error}, 64'h0);

        // First vector: done 5 cycles after start
        expect_issue();
        press();
        check("issue_busy", 64'(busy), 64'd1);
        check("issue_no_start", 64'(fpu_start), 64'd0);
        tick();
        check("wait_start", 64'(fpu_start), 64'd1);
        repeat (4) begin
            tick();
            check("wait_busy", {55'h0, busy, leds}, {55'h0, 1'b1, 8'h00});
        end
        tick();
        fpu_done   = 1'b1;
        fpu_result = 32'h4049_0FDB;
        tick();
        fpu_done   = 1'b0;
        check("show_byte3", {48'h0, leds, 6'h0, busy, error}, {48'h0, 8'h40, 8'h00});
        check("operands_held", {fpu_a, fpu_b}, rom_model(0));
        press();
        check("show_byte2", 64'(leds), 64'h49);
        press();
        check("show_byte1", 64'(leds), 64'h0F);
        press();
        check("show_byte0", 64'(leds), 64'hDB);

        // Second vector, no answer: timeout path
        exp_idx = 1;
        expect_issue();
        press();
        check("issue2_leds_hold", 64'(leds), 64'hDB);
        tick();
        begin
            int waited;
            waited = 0;
            for (int i = 1; i <= 40; i++) begin
                tick();
                waited = i;
                if (!busy) break;
            end
            check("timeout_cycles", 64'(waited), 64'(TO));
        end
        check("timeout_show", {48'h0, leds, 6'h0, busy, error}, {48'h0, 8'hDE, 8'h01});
        press();
        check("err_byte2", 64'(leds), 64'hAD);
        press();
        check("err_byte1", 64'(leds), 64'hBE);
        press();
        check("err_byte0", {56'h0, leds}, 64'hEF);

        // Third vector: error clears on issue, presses during WAIT dropped
        exp_idx = 2;
        expect_issue();
        press();
        check("issue_error_sticky", 64'(error), 64'd1);
        tick();
        check("wait_error_cleared", 64'(error), 64'd0);
        button_pulse = 1'b1;
        tick();
        button_pulse = 1'b0;
        check("wait_press_ignored", 64'(busy), 64'd1);
        tick();
        tick();
        fpu_done   = 1'b1;
        fpu_result = 32'h3F81_2233;
        tick();
        fpu_done   = 1'b0;
        check("v2_byte3", {48'h0, leds, 7'h0, busy}, {48'h0, 8'h3F, 8'h00});
        press();
        check("v2_byte2", 64'(leds), 64'h81);
        fpu_done   = 1'b1;
        fpu_result = 32'hFFFF_FFFF;
        tick();
        fpu_done   = 1'b0;
        check("show_stray_done", {48'h0, leds, 7'h0, busy}, {48'h0, 8'h81, 8'h00});
        press();
        check("v2_byte1", 64'(leds), 64'h22);
        press();
        check("v2_byte0", 64'(leds), 64'h33);

        // Fourth vector: press and done during ISSUE and WAIT ignored
        exp_idx = 3;
        expect_issue();
        press();
        button_pulse = 1'b1;
        fpu_done     = 1'b1;
        tick();
        button_pulse = 1'b0;
        fpu_done     = 1'b0;
        check("issue_stray_ignored", {62'h0, busy, fpu_start}, 64'd3);
        button_pulse = 1'b1;
        tick();
        button_pulse = 1'b0;
        check("wait_press2_ignored", 64'(busy), 64'd1);
        fpu_done   = 1'b1;
        fpu_result = 32'hC012_3456;
        tick();
        fpu_done   = 1'b0;
        check("v3_byte3", 64'(leds), 64'hC0);
        press();
        check("v3_byte2", 64'(leds), 64'h12);
        press();
        press();
        check("v3_byte0", 64'(leds), 64'h56);

        // Wrap to vector 0, then reset mid-WAIT with done right after release
        exp_idx = 0;
        expect_issue();
        press();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("midwait_rst", {39'h0, fpu_start, leds, busy, error, 14'h0}, 64'h0);
        check("midwait_rst_ops", {fpu_a, fpu_b}, 64'h0);
        reset      = 1'b1;
        fpu_done   = 1'b1;
        fpu_result = 32'h1234_5678;
        tick();
        fpu_done   = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", {48'h0, leds, 5'h0, fpu_start, busy, error}, 64'h0);

        // NUM_VECTORS+1 vectors with done in the start cycle; final start wraps to ROM[0]
        exp_idx = 0;
        for (int v = 0; v <= int'(NV); v++) begin
            logic [31:0] pat;
            pat = {8'(v + 1), 8'hA5, 8'(v * 3), 8'h5A};
            expect_issue();
            press();
            tick();
            check("loop_start", 64'(fpu_start), 64'd1);
            fpu_done   = 1'b1;
            fpu_result = pat;
            tick();
            fpu_done   = 1'b0;
            check("loop_byte3", 64'(leds), 64'(pat[31:24]));
            press();
            check("loop_byte2", 64'(leds), 64'(pat[23:16]));
            press();
            check("loop_byte1", 64'(leds), 64'(pat[15:8]));
            press();
            check("loop_byte0", 64'(leds), 64'(pat[7:0]));
            exp_idx = (exp_idx + 1) % int'(NV);
        end

        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("start_count", 64'(n_starts), 64'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
